uart_tx_arbiter: RTL and testbench

//  Shares one byte-serial UART transmitter between NUM_REQ requesters (CPU store port, debug echo, trace).

---
 rtl/uart_tx_arbiter_pkg.sv | 18 +
 rtl/uart_tx_arbiter_rr_pick.sv | 29 ++
 rtl/uart_tx_arbiter.sv | 112 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encodings, transmitter
// status levels and default sizing.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

  localparam logic TX_STATUS_IDLE = 1'b1;
  localparam logic TX_STATUS_BUSY = 1'b0;

  localparam int DEFAULT_NUM_REQ     = 4;
  localparam int DEFAULT_TIMEOUT_CYC = 16;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit scanning upward from
// the slot after last_gnt, wrapping modulo NUM_REQ.
module rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_gnt,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0] cand;

  // Scan farthest slot first so the nearest set slot overwrites and wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IDX_W'((int'(last_gnt) + k) % NUM_REQ);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one byte-serial UART transmitter between NUM_REQ
// requesters, one byte per grant, with a start timeout on the transmitter.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter  int NUM_REQ     = DEFAULT_NUM_REQ,
  parameter  int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC,
  localparam int IDX_W       = $clog2(NUM_REQ),
  localparam int CNT_W       = $clog2(TIMEOUT_CYC)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 tx_en,
  output logic [7:0]           tx_data,
  input  logic                 tx_status,
  output logic                 busy,
  output logic                 err,
  output logic [IDX_W-1:0]     last_gnt
);

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [NUM_REQ-1:0] ack_d;
  logic               tx_en_d;
  logic [7:0]         tx_data_d;
  logic               busy_d;
  logic               err_d;
  logic [IDX_W-1:0]   last_gnt_d;

  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req      (req),
    .last_gnt (last_gnt),
    .valid    (pick_valid),
    .idx      (pick_idx)
  );

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    ack_d      = '0;
    tx_en_d    = 1'b0;
    err_d      = 1'b0;
    tx_data_d  = tx_data;
    last_gnt_d = last_gnt;
    case (state)
      ST_IDLE: begin
        if (enable && (tx_status == TX_STATUS_IDLE) && pick_valid) begin
          state_d         = ST_LAUNCH;
          tx_data_d       = req_data[8*int'(pick_idx) +: 8];
          last_gnt_d      = pick_idx;
          tx_en_d         = 1'b1;
          ack_d[pick_idx] = 1'b1;
        end
      end
      ST_LAUNCH: begin
        cnt_d   = '0;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (tx_status == TX_STATUS_BUSY) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
          // Transmitter never started: abort, keep last_gnt on the aborted slot.
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (tx_status == TX_STATUS_IDLE) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      ack      <= '0;
      tx_en    <= 1'b0;
      tx_data  <= 8'h00;
      busy     <= 1'b0;
      err      <= 1'b0;
      last_gnt <= IDX_W'(NUM_REQ - 1);
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      ack      <= ack_d;
      tx_en    <= tx_en_d;
      tx_data  <= tx_data_d;
      busy     <= busy_d;
      err      <= err_d;
      last_gnt <= last_gnt_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed scoreboard bench for uart_tx_arbiter with a behavioural UART
// transmitter that holds its status low for a fixed frame length.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ     = 4;
  localparam int TIMEOUT_CYC = 16;
  localparam int IDX_W       = $clog2(NUM_REQ);
  localparam int FRAME_LEN   = 100;
  localparam int WAIT_MAX    = 400;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 enable = 1'b1;
  logic [NUM_REQ-1:0]   req = '0;
  logic [8*NUM_REQ-1:0] req_data = '0;
  logic [NUM_REQ-1:0]   ack;
  logic                 tx_en;
  logic [7:0]           tx_data;
  logic                 tx_status = 1'b1;
  logic                 busy;
  logic                 err;
  logic [IDX_W-1:0]     last_gnt;

  typedef struct {
    bit         is_err;
    int         idx;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   stuck = 1'b0;
  int   frame_cnt = 0;

  uart_tx_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .req       (req),
    .req_data  (req_data),
    .ack       (ack),
    .tx_en     (tx_en),
    .tx_data   (tx_data),
    .tx_status (tx_status),
    .busy      (busy),
    .err       (err),
    .last_gnt  (last_gnt)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Behavioural transmitter, reset by the same rst.
  always @(negedge clk) begin
    if (rst) begin
      tx_status = 1'b1;
      frame_cnt = 0;
    end else if (tx_en && !stuck) begin
      tx_status = 1'b0;
      frame_cnt = FRAME_LEN;
    end else if (frame_cnt > 0) begin
      frame_cnt--;
      if (frame_cnt == 0) tx_status = 1'b1;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT launches a byte or aborts.
  int                 cyc = 0;
  int                 en_cyc = 0;
  logic               prev_en = 1'b0;
  exp_t               mon_e;
  logic [NUM_REQ-1:0] mon_oh;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (!rst) begin
      if (ack != '0 && !tx_en) begin
        vectors++;
        miscompares++;
        $display("FAIL ack_without_tx_en: actual ack=%0h tx_en=0 required tx_en=1", ack);
      end
      if (tx_en) begin
        if (prev_en) begin
          vectors++;
          miscompares++;
          $display("FAIL tx_en_width: actual 2+ cycles required 1");
        end
        en_cyc = cyc;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_tx_en: actual data=%0h ack=%0h required none", tx_data, ack);
        end else begin
          mon_e = exp_q.pop_front();
          mon_oh = '0;
          mon_oh[mon_e.idx] = 1'b1;
          check("launch_kind", 32'(mon_e.is_err), 32'(0));
          check("launch_tx_data", 32'(tx_data), 32'(mon_e.data));
          check("launch_ack", 32'(ack), 32'(mon_oh));
          check("launch_last_gnt", 32'(last_gnt), 32'(mon_e.idx));
        end
      end
      if (err) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_err: actual err=1 required 0");
        end else begin
          mon_e = exp_q.pop_front();
          check("err_kind", 32'(mon_e.is_err), 32'(1));
          check("err_delay", 32'(cyc - en_cyc), 32'(TIMEOUT_CYC + 1));
        end
      end
    end
    prev_en = tx_en;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_byte(input int i, input logic [7:0] b);
    req_data[8*i +: 8] = b;
  endtask

  task automatic expect_launch(input int idx, input logic [7:0] data);
    exp_t e;
    e.is_err = 1'b0;
    e.idx    = idx;
    e.data   = data;
    exp_q.push_back(e);
  endtask

  task automatic expect_err();
    exp_t e;
    e.is_err = 1'b1;
    e.idx    = 0;
    e.data   = 8'h00;
    exp_q.push_back(e);
  endtask

  task automatic wait_ack(input string name);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (ack == '0 && n < WAIT_MAX);
    if (ack == '0) fail_now(name);
  endtask

  task automatic wait_status(input logic lvl, input string name);
    int n;
    n = 0;
    while (tx_status !== lvl && n < WAIT_MAX) begin
      tick();
      n++;
    end
    if (tx_status !== lvl) fail_now(name);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy || !tx_status) && n < WAIT_MAX) begin
      tick();
      n++;
    end
    if (busy || !tx_status) fail_now(name);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset: three cycles with the transmitter idle.
    rst = 1'b1;
    repeat (3) tick();
    check("rst_ack", 32'(ack), 32'(0));
    check("rst_tx_en", 32'(tx_en), 32'(0));
    check("rst_tx_data", 32'(tx_data), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_err", 32'(err), 32'(0));
    check("rst_last_gnt", 32'(last_gnt), 32'(3));
    rst = 1'b0;
    tick();

    // Fairness: all four held, order 0,1,2,3,0.
    for (int i = 0; i < NUM_REQ; i++) set_byte(i, 8'h10 + 8'(i));
    expect_launch(0, 8'h10);
    expect_launch(1, 8'h11);
    expect_launch(2, 8'h12);
    expect_launch(3, 8'h13);
    expect_launch(0, 8'h10);
    req = 4'b1111;
    for (int g = 0; g < 5; g++) wait_ack("fair_ack");
    req = 4'b0000;
    wait_idle("fair_idle");
    check("fair_last_gnt", 32'(last_gnt), 32'(0));

    // Single request on slot 2: grant one edge after req rises.
    set_byte(2, 8'hA5);
    expect_launch(2, 8'hA5);
    req = 4'b0100;
    tick();
    check("single_latency_ack", 32'(ack), 32'(4'b0100));
    check("single_latency_tx_en", 32'(tx_en), 32'(1));
    req = 4'b0000;
    wait_status(1'b0, "single_status_low");
    check("single_busy_mid", 32'(busy), 32'(1));
    wait_status(1'b1, "single_status_high");
    check("single_busy_end", 32'(busy), 32'(0));

    // Timeout: transmitter never drops status.
    stuck = 1'b1;
    set_byte(1, 8'h5C);
    expect_launch(1, 8'h5C);
    expect_err();
    req = 4'b0010;
    wait_ack("to_ack");
    req = 4'b0000;
    n = 0;
    while (!err && n < WAIT_MAX) begin
      tick();
      n++;
    end
    if (!err) fail_now("to_err");
    check("to_busy", 32'(busy), 32'(0));
    check("to_last_gnt", 32'(last_gnt), 32'(1));
    stuck = 1'b0;
    set_byte(0, 8'h3E);
    set_byte(3, 8'hE7);
    expect_launch(3, 8'hE7);
    req = 4'b1001;
    wait_ack("to_next_ack");
    req = 4'b0000;
    wait_idle("to_next_idle");

    // enable dropped during WAIT_DONE with slots 0 and 1 pending.
    set_byte(2, 8'h77);
    expect_launch(2, 8'h77);
    req = 4'b0100;
    wait_ack("en_first_ack");
    req = 4'b0000;
    wait_status(1'b0, "en_status_low");
    enable = 1'b0;
    set_byte(0, 8'h40);
    set_byte(1, 8'h41);
    req = 4'b0011;
    wait_idle("en_frame_end");
    repeat (10) tick();
    check("en_hold_busy", 32'(busy), 32'(0));
    check("en_hold_last_gnt", 32'(last_gnt), 32'(2));
    expect_launch(0, 8'h40);
    expect_launch(1, 8'h41);
    enable = 1'b1;
    wait_ack("en_resume_ack0");
    req = 4'b0010;
    wait_ack("en_resume_ack1");
    req = 4'b0000;
    wait_idle("en_resume_idle");

    // rst pulse in WAIT_DONE; slot 3 pending wins after reset.
    set_byte(0, 8'h81);
    expect_launch(0, 8'h81);
    req = 4'b0001;
    wait_ack("rst_frame_ack");
    req = 4'b0000;
    wait_status(1'b0, "rst_status_low");
    repeat (5) tick();
    set_byte(3, 8'hC3);
    req = 4'b1000;
    rst = 1'b1;
    expect_launch(3, 8'hC3);
    tick();
    check("rst_mid_busy", 32'(busy), 32'(0));
    check("rst_mid_ack", 32'(ack), 32'(0));
    check("rst_mid_err", 32'(err), 32'(0));
    check("rst_mid_last_gnt", 32'(last_gnt), 32'(3));
    rst = 1'b0;
    wait_ack("rst_after_ack");
    req = 4'b0000;
    wait_idle("rst_after_idle");

    n = 0;
    while (exp_q.size() != 0 && n < WAIT_MAX) begin
      tick();
      n++;
    end
    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
